// File: rtl/router_fifo_pkt.sv
// Packet-aware synchronous FIFO for a router output channel.
// Stores each word with its header marker, tracks the remaining words of the
// packet being read, and reports occupancy plus rejected-request pulses.
module router_fifo_pkt #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_MARGIN  = 2,
   localparam int AW        = $clog2(DEPTH),
   localparam int PW        = DATA_WIDTH - 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  soft_reset,
   input  logic                  write_enb,
   input  logic                  lfd_state,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_enb,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_valid,
   output logic                  sop_out,
   output logic                  eop_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [AW:0]           count,
   output logic                  pkt_busy,
   output logic                  overflow,
   output logic                  underflow
);

   // storage: MSB is the header marker
   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [DATA_WIDTH:0]   rd_word;

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic [PW-1:0]         pkt_rem_q, pkt_rem_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  flush;
   logic                  wr_ok, rd_ok;

   // flags come straight from the registered occupancy
   assign empty       = (count_q == '0);
   assign full        = (count_q == (AW+1)'(DEPTH));
   assign almost_full = (int'(count_q) >= DEPTH - AF_MARGIN);

   assign flush = reset | soft_reset;
   assign wr_ok = write_enb & ~full  & ~flush;
   assign rd_ok = read_enb  & ~empty & ~flush;
   assign rd_word = mem_q[rd_ptr_q];

   assign data_out  = data_out_q;
   assign rd_valid  = rd_valid_q;
   assign sop_out   = sop_q;
   assign eop_out   = eop_q;
   assign count     = count_q;
   assign pkt_busy  = (pkt_rem_q != '0);
   assign overflow  = ovf_q;
   assign underflow = unf_q;

   // memory write port; contents survive reset and flush
   always_ff @(posedge clock) begin
      if (wr_ok) mem_q[wr_ptr_q] <= {lfd_state, data_in};
   end

   // next-state: pointers, occupancy, read register and packet tracking
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pkt_rem_d  = pkt_rem_q;
      data_out_d = data_out_q;
      rd_valid_d = 1'b0;
      sop_d      = 1'b0;
      eop_d      = 1'b0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         pkt_rem_d  = '0;
         data_out_d = '0;
      end else begin
         ovf_d = write_enb & full;
         unf_d = read_enb & empty;
         if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = rd_word[DATA_WIDTH-1:0];
            rd_valid_d = 1'b1;
            if (rd_word[DATA_WIDTH]) begin
               // header (also restarts a truncated packet): payload + parity
               pkt_rem_d = PW'(rd_word[DATA_WIDTH-1:2]) + PW'(1);
               sop_d     = 1'b1;
            end else if (pkt_rem_q != '0) begin
               pkt_rem_d = pkt_rem_q - PW'(1);
               eop_d     = (pkt_rem_q == PW'(1));
            end
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // state registers with synchronous full reset
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pkt_rem_q  <= '0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pkt_rem_q  <= pkt_rem_d;
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Scoreboard bench for router_fifo_pkt: a queue-based reference model predicts
// each read response; a negedge monitor compares outputs and flags.
module tb_router_fifo_pkt;

   localparam int DEPTH = 16;
   localparam int AFM   = 2;

   logic       clock = 1'b0;
   logic       reset, soft_reset, write_enb, lfd_state, read_enb;
   logic [7:0] data_in, data_out;
   logic       rd_valid, sop_out, eop_out, empty, full, almost_full;
   logic [4:0] count;
   logic       pkt_busy, overflow, underflow;

   router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
      .clock(clock), .reset(reset), .soft_reset(soft_reset),
      .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
      .read_enb(read_enb), .data_out(data_out), .rd_valid(rd_valid),
      .sop_out(sop_out), .eop_out(eop_out), .empty(empty), .full(full),
      .almost_full(almost_full), .count(count), .pkt_busy(pkt_busy),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   // reference model state
   logic [8:0] mq[$];      // stored {marker, data}
   logic [9:0] sb[$];      // expected {sop, eop, data}
   int         m_rem = 0;
   logic [7:0] m_dout = '0;
   bit         e_vld = 0, e_ovf = 0, e_unf = 0;
   bit         unf_dc = 0;
   bit         mon_en = 0;
   int         checks = 0, failures = 0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // one clock of stimulus; model advances by the specification's rules
   task automatic cyc(input bit rst, input bit srst, input bit we, input bit lfd,
                      input logic [7:0] din, input bit re);
      bit wa, ra;
      logic [8:0] w;
      bit sop, eop;
      reset = rst; soft_reset = srst; write_enb = we; lfd_state = lfd;
      data_in = din; read_enb = re;
      @(posedge clock); #1;
      e_vld = 0; e_ovf = 0; e_unf = 0;
      if (rst || srst) begin
         mq.delete(); m_rem = 0; m_dout = '0;
      end else begin
         wa = we && (mq.size() < DEPTH);
         ra = re && (mq.size() > 0);
         e_ovf = we && (mq.size() == DEPTH);
         e_unf = re && (mq.size() == 0);
         if (ra) begin
            w = mq.pop_front();
            sop = 0; eop = 0;
            if (w[8]) begin
               sop = 1;
               m_rem = int'(w[7:2]) + 1;
            end else if (m_rem > 0) begin
               eop = (m_rem == 1);
               m_rem = m_rem - 1;
            end
            sb.push_back({sop, eop, w[7:0]});
            m_dout = w[7:0];
            e_vld = 1;
         end
         if (wa) mq.push_back({lfd, din});
      end
   endtask

   task automatic wr(input bit lfd, input logic [7:0] d);
      cyc(0, 0, 1, lfd, d, 0);
   endtask

   task automatic rd(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 8'h00, 1);
   endtask

   // monitor: pops the scoreboard on every presented read
   always @(negedge clock) begin
      logic [9:0] e;
      if (mon_en) begin
         chk("rd_valid", int'(rd_valid), int'(e_vld));
         if (rd_valid) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_read: got data %0h expected none", data_out);
            end else begin
               e = sb.pop_front();
               chk("data", int'(data_out), int'(e[7:0]));
               chk("sop",  int'(sop_out),  int'(e[9]));
               chk("eop",  int'(eop_out),  int'(e[8]));
            end
         end else begin
            chk("sop_idle", int'(sop_out), 0);
            chk("eop_idle", int'(eop_out), 0);
         end
         chk("data_hold",   int'(data_out),    int'(m_dout));
         chk("count",       int'(count),       mq.size());
         chk("empty",       int'(empty),       int'(mq.size() == 0));
         chk("full",        int'(full),        int'(mq.size() == DEPTH));
         chk("almost_full", int'(almost_full), int'(mq.size() >= DEPTH - AFM));
         chk("pkt_busy",    int'(pkt_busy),    int'(m_rem != 0));
         chk("overflow",    int'(overflow),    int'(e_ovf));
         if (!unf_dc) chk("underflow", int'(underflow), int'(e_unf));
      end
   end

   initial begin
      // reset and flush
      cyc(1, 0, 0, 0, 8'h00, 0);
      mon_en = 1;
      for (int i = 0; i < 3; i++) wr(0, 8'(8'hA0 + i));
      cyc(0, 1, 0, 0, 8'h00, 0);
      rd(1);
      cyc(0, 0, 0, 0, 8'h00, 0);

      // packet read: header 0x15 = len 5, then 5 payload + parity
      wr(1, 8'h15);
      for (int i = 0; i < 6; i++) wr(0, 8'($urandom_range(0, 255)));
      rd(7);

      // fill to full, then overflow
      for (int i = 0; i < 14; i++) wr(0, 8'($urandom_range(0, 255)));
      wr(0, 8'h11); wr(0, 8'h22);
      wr(0, 8'h33);

      // simultaneous while full: read accepted, write rejected
      cyc(0, 0, 1, 0, 8'h44, 1);
      rd(15);
      cyc(0, 0, 0, 0, 8'h00, 0);
      // simultaneous while empty: only the write lands
      unf_dc = 1;
      cyc(0, 0, 1, 0, 8'h55, 1);
      unf_dc = 0;

      // wrap-around streaming at one word of occupancy
      for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0, 8'($urandom_range(0, 255)), 1);
      rd(1);

      // zero-length packet
      wr(1, 8'h01); wr(0, 8'h5A);
      rd(2);
      // truncated packet followed by a new header
      wr(1, 8'h15); wr(0, 8'h01); wr(0, 8'h02);
      wr(1, 8'h09); wr(0, 8'h03); wr(0, 8'h04); wr(0, 8'h05);
      rd(7);

      // randomized traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
             bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
             8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
      end
      rd(DEPTH + 1);
      cyc(0, 0, 0, 0, 8'h00, 0);
      @(posedge clock); #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
